// File: rtl/execution_mc.sv
`default_nettype none
// ============================================================================
//  Module   : execution_mc
//  Purpose  : Multi-cycle execute stage. Forwarding muxes on both operands,
//             immediate select on operand B, single-cycle logic/arith ops,
//             iterative shift-add MUL and restoring UDIV (one bit per cycle),
//             registered result with valid/ready handshakes.
//  Ports    : clk, reset (sync, active-high)
//             in_valid/in_ready      - operation handshake
//             read_data_1/2, imm     - operand sources
//             alu_src, alu_ctrl      - B-operand select, operation code
//             forward_a/b            - 00 regfile, 10 EX/MEM, 01 WB, 11 zero
//             ex_mem_result, wb_result - forwarding sources
//             flush                  - abort in-flight op, drop held result
//             out_valid/out_ready    - result handshake
//             result, store_data, zero, flags {N,Z,C,V}, busy
//  Revision : 1.0 - initial release
// ============================================================================
module execution_mc #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] read_data_1,
    input  logic [WIDTH-1:0] read_data_2,
    input  logic [WIDTH-1:0] imm,
    input  logic             alu_src,
    input  logic [3:0]       alu_ctrl,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [WIDTH-1:0] ex_mem_result,
    input  logic [WIDTH-1:0] wb_result,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] store_data,
    output logic             zero,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [3:0] C_OP_AND  = 4'b0000;
    localparam logic [3:0] C_OP_ORR  = 4'b0001;
    localparam logic [3:0] C_OP_ADD  = 4'b0010;
    localparam logic [3:0] C_OP_SUB  = 4'b0110;
    localparam logic [3:0] C_OP_PASS = 4'b0111;
    localparam logic [3:0] C_OP_NOR  = 4'b1100;
    localparam logic [3:0] C_OP_MUL  = 4'b1000;
    localparam logic [3:0] C_OP_DIV  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_opa;   // MUL: multiplicand, shifted left each step
    logic [WIDTH-1:0] r_opb;   // DIV: divisor
    logic [WIDTH-1:0] r_acc;   // MUL: partial product / DIV: partial remainder
    logic [WIDTH-1:0] r_quo;   // MUL: multiplier (shifted right) / DIV: dividend->quotient

    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_fwd_b;
    logic [WIDTH-1:0] w_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_c;
    logic             w_alu_v;
    logic             w_accept;
    logic [WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem_next;
    logic [WIDTH-1:0] w_div_quo_next;
    logic [WIDTH-1:0] w_fin_res;

    assign in_ready = (r_state == S_IDLE) && (!out_valid || out_ready);
    assign busy     = (r_state != S_IDLE);
    assign w_accept = in_valid && in_ready;

    // Operand forwarding
    always_comb begin
        w_a = '0;
        case (forward_a)
            2'b00:   w_a = read_data_1;
            2'b10:   w_a = ex_mem_result;
            2'b01:   w_a = wb_result;
            default: w_a = '0;
        endcase
    end

    always_comb begin
        w_fwd_b = '0;
        case (forward_b)
            2'b00:   w_fwd_b = read_data_2;
            2'b10:   w_fwd_b = ex_mem_result;
            2'b01:   w_fwd_b = wb_result;
            default: w_fwd_b = '0;
        endcase
    end

    assign w_b    = alu_src ? imm : w_fwd_b;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = w_a - w_b;

    // Single-cycle ALU
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (alu_ctrl)
            C_OP_AND:  w_alu_res = w_a & w_b;
            C_OP_ORR:  w_alu_res = w_a | w_b;
            C_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                // Overflow: like-signed operands producing a differently-signed sum
                w_alu_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            C_OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_c   = (w_a >= w_b);
                w_alu_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            C_OP_PASS: w_alu_res = w_b;
            C_OP_NOR:  w_alu_res = ~(w_a | w_b);
            default:   w_alu_res = '0;
        endcase
    end

    // Iteration steps
    assign w_mul_next     = r_quo[0] ? (r_acc + r_opa) : r_acc;
    assign w_div_shift    = {r_acc, r_quo[WIDTH-1]};
    assign w_div_ge       = (w_div_shift >= {1'b0, r_opb});
    // Remainder always stays below the divisor, so it fits in WIDTH bits
    assign w_div_rem_next = w_div_ge ? WIDTH'(w_div_shift - {1'b0, r_opb})
                                     : w_div_shift[WIDTH-1:0];
    assign w_div_quo_next = {r_quo[WIDTH-2:0], w_div_ge};
    // Divide by zero returns 0 rather than the all-ones the datapath produces
    assign w_fin_res      = (r_state == S_MUL) ? w_mul_next
                          : ((r_opb == '0) ? '0 : w_div_quo_next);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_opa      <= '0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_quo      <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            store_data <= '0;
            zero       <= 1'b1;
            flags      <= 4'b0000;
        end else if (flush) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        store_data <= w_fwd_b;
                        if (alu_ctrl == C_OP_MUL) begin
                            r_state   <= S_MUL;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_opa     <= w_a;
                            r_quo     <= w_b;
                            r_acc     <= '0;
                            out_valid <= 1'b0;
                        end else if (alu_ctrl == C_OP_DIV) begin
                            r_state   <= S_DIV;
                            r_cnt     <= CNT_W'(WIDTH);
                            r_quo     <= w_a;
                            r_opb     <= w_b;
                            r_acc     <= '0;
                            out_valid <= 1'b0;
                        end else begin
                            result    <= w_alu_res;
                            zero      <= (w_alu_res == '0);
                            flags     <= {w_alu_res[WIDTH-1], (w_alu_res == '0),
                                          w_alu_c, w_alu_v};
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_state == S_MUL) begin
                        r_acc <= w_mul_next;
                        r_opa <= {r_opa[WIDTH-2:0], 1'b0};
                        r_quo <= {1'b0, r_quo[WIDTH-1:1]};
                    end else begin
                        r_acc <= w_div_rem_next;
                        r_quo <= w_div_quo_next;
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state   <= S_IDLE;
                        result    <= w_fin_res;
                        zero      <= (w_fin_res == '0);
                        flags     <= {w_fin_res[WIDTH-1], (w_fin_res == '0), 2'b00};
                        out_valid <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
